rv32i_reorder_buffer: RTL

In-order retirement buffer for the RV32I out-of-order core; the initiator side of the register file's retire interface. The dispatcher allocates one entry per instruction, carrying its DST architectural index and the physical tag the register file assigned to it. Writeback marks entries complete. The buffer then retires the oldest completed entry once per cycle on the retire bus (`o_retire*`) that feeds the register file's RAT-commit inputs.

---
 rtl/rv32i_pkg.sv | 19 +
 rtl/rv32i_rob_ptr.sv | 22 ++
 rtl/rv32i_reorder_buffer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/rv32i_pkg.sv
// Shared RV32I core types and widths used by the reorder buffer.
package rv32i_pkg;

  localparam int ARCH_REG_FILE_IDX_BW = 5;
  localparam int PHYS_REG_FILE_IDX_BW = 6;
  localparam int NUM_ROB_ENTRIES      = 16;
  localparam int ROB_IDX_BW           = $clog2(NUM_ROB_ENTRIES);

  // One reorder-buffer slot: occupancy, completion and the destination mapping
  // handed to the register file when the slot retires.
  typedef struct packed {
    logic                            vld;
    logic                            done;
    logic                            dst_vld;
    logic [ARCH_REG_FILE_IDX_BW-1:0] arch_idx;
    logic [PHYS_REG_FILE_IDX_BW-1:0] phys_idx;
  } rob_entry_t;

endpackage

// File: rtl/rv32i_rob_ptr.sv
// Wrap-bit circular pointer: IDX_BW index bits plus one MSB wrap bit.
// Relies on the buffer depth being a power of two so natural overflow wraps.
module rv32i_rob_ptr #(
  parameter int IDX_BW = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            inc,
  output logic [IDX_BW:0] ptr
);

  // Clear wins over increment so a flush always lands both pointers at zero.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= ptr + 1'b1;
    end
  end

endmodule

// File: rtl/rv32i_reorder_buffer.sv
// In-order retirement buffer feeding the register file's RAT-commit port.
// Optional build macro ROB_WB_BYPASS_EN: a writeback to the head entry may
// retire in the same cycle (1-cycle wb->retire instead of 2).
module rv32i_reorder_buffer
  import rv32i_pkg::*;
#(
  parameter  int DEPTH  = NUM_ROB_ENTRIES,
  localparam int IDX_BW = $clog2(DEPTH)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            i_alloc,
  input  logic                            i_alloc_dst_vld,
  input  logic [ARCH_REG_FILE_IDX_BW-1:0] i_alloc_arch_rf_idx,
  input  logic [PHYS_REG_FILE_IDX_BW-1:0] i_alloc_phys_rf_idx,
  output logic                            o_alloc_rdy,
  output logic [IDX_BW-1:0]               o_alloc_rob_idx,
  input  logic                            i_wb_vld,
  input  logic [IDX_BW-1:0]               i_wb_rob_idx,
  input  logic                            i_flush,
  output logic                            o_retire,
  output logic                            o_retire_dst_vld,
  output logic [ARCH_REG_FILE_IDX_BW-1:0] o_retire_arch_rf_idx,
  output logic [PHYS_REG_FILE_IDX_BW-1:0] o_retire_phys_rf_idx,
  output logic                            o_empty,
  output logic [IDX_BW:0]                 o_count
);

  logic [IDX_BW:0]   head_ptr;
  logic [IDX_BW:0]   tail_ptr;
  logic [IDX_BW-1:0] head_idx;
  logic [IDX_BW-1:0] tail_idx;
  logic              full;
  logic              alloc_fire;
  logic              wb_hit_head;
  logic              ret_go;
  logic              ret_fire;
  rob_entry_t        entries [DEPTH];
  rob_entry_t        head_entry;

  assign head_idx = head_ptr[IDX_BW-1:0];
  assign tail_idx = tail_ptr[IDX_BW-1:0];

  // Full when indices match but the wrap bits disagree; empty when identical.
  assign full        = (head_idx == tail_idx) && (head_ptr[IDX_BW] != tail_ptr[IDX_BW]);
  assign o_count     = tail_ptr - head_ptr;
  assign o_empty     = (head_ptr == tail_ptr);
  assign o_alloc_rdy = !full;
  assign o_alloc_rob_idx = tail_idx;

  // Readiness uses the pre-retire occupancy, so a full buffer never accepts
  // an alloc even in a cycle that frees the head.
  assign alloc_fire = i_alloc && o_alloc_rdy && !i_flush;

  assign head_entry  = entries[head_idx];
  assign wb_hit_head = i_wb_vld && (i_wb_rob_idx == head_idx);

`ifdef ROB_WB_BYPASS_EN
  assign ret_go = head_entry.vld && (head_entry.done || wb_hit_head);
`else
  assign ret_go = head_entry.vld && head_entry.done;
`endif

  // Flush outranks retirement.
  assign ret_fire = ret_go && !i_flush;

  rv32i_rob_ptr #(.IDX_BW(IDX_BW)) u_head_ptr (
    .clk (clk),
    .rst (rst),
    .clr (i_flush),
    .inc (ret_fire),
    .ptr (head_ptr)
  );

  rv32i_rob_ptr #(.IDX_BW(IDX_BW)) u_tail_ptr (
    .clk (clk),
    .rst (rst),
    .clr (i_flush),
    .inc (alloc_fire),
    .ptr (tail_ptr)
  );

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
      rob_entry_t entry_reg;

      // Per-slot update: flush/reset, then alloc, then retire-clear, then writeback.
      // Alloc and retire never target the same slot since a full buffer rejects alloc.
      always_ff @(posedge clk) begin
        if (rst || i_flush) begin
          entry_reg.vld  <= 1'b0;
          entry_reg.done <= 1'b0;
        end else if (alloc_fire && (tail_idx == IDX_BW'(gi))) begin
          entry_reg.vld      <= 1'b1;
          entry_reg.done     <= 1'b0;
          entry_reg.dst_vld  <= i_alloc_dst_vld;
          entry_reg.arch_idx <= i_alloc_arch_rf_idx;
          entry_reg.phys_idx <= i_alloc_phys_rf_idx;
        end else if (ret_fire && (head_idx == IDX_BW'(gi))) begin
          entry_reg.vld  <= 1'b0;
          entry_reg.done <= 1'b0;
        end else if (i_wb_vld && (i_wb_rob_idx == IDX_BW'(gi)) && entry_reg.vld) begin
          entry_reg.done <= 1'b1;
        end
      end

      assign entries[gi] = entry_reg;
    end
  endgenerate

  // Retire bus: one registered pulse per retired entry; payload holds between retires.
  always_ff @(posedge clk) begin
    if (rst) begin
      o_retire             <= 1'b0;
      o_retire_dst_vld     <= 1'b0;
      o_retire_arch_rf_idx <= '0;
      o_retire_phys_rf_idx <= '0;
    end else if (ret_fire) begin
      o_retire             <= 1'b1;
      o_retire_dst_vld     <= head_entry.dst_vld;
      o_retire_arch_rf_idx <= head_entry.arch_idx;
      o_retire_phys_rf_idx <= head_entry.phys_idx;
    end else begin
      o_retire <= 1'b0;
    end
  end

endmodule
